mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 9, memory address width.
REQ-002 Parameter DW, default 16, data width.
REQ-003 Parameter RD_LAT, default 1, memory read latency in cycles from command issue to mem_rdata valid; legal range 1..3.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 a_req, a_cmd[1:0], a_addr[AW-1:0], a_wdata[DW-1:0]  in  requester A (CPU): request, command, address, write data.
REQ-007 a_gnt  out  1  A's request is accepted this cycle.
REQ-008 a_rvalid  out  1  a_rdata holds A's read data this cycle.
REQ-009 a_rdata  out  DW  A's read data.
REQ-010 b_req, b_cmd, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same widths and directions as the A signals  requester B (loader/IO).
REQ-011 mem_cmd  out  2  command to RAM.
REQ-012 mem_addr  out  AW  address to RAM.
REQ-013 mem_wdata  out  DW  write data to RAM.
REQ-014 mem_rdata  in  DW  RAM read data, valid RD_LAT cycles after issue.

Function
REQ-015 Command encoding: NONE=2'b00, READ=2'b01, WRITE=2'b10; 2'b11 is treated as NONE.
REQ-016 A requester is eligible in a cycle when x_req=1 and x_cmd is READ or WRITE; a request with NONE is ignored and gets no gnt.
REQ-017 At most one gnt per cycle; gnt is combinational from the eligible requests and the registered priority pointer.
REQ-018 Priority pointer states: PRI_A and PRI_B. On a conflict the prioritised port wins; after any grant the pointer moves to the other port (round-robin); with no grant the pointer holds.
REQ-019 A single eligible requester is granted in the same cycle regardless of the pointer.
REQ-020 The accepted cmd, addr and wdata are registered onto mem_cmd, mem_addr and mem_wdata in the cycle after gnt, for exactly one cycle; otherwise mem_cmd=NONE.
REQ-021 Back-to-back: a new grant is allowed every cycle, giving one memory command per cycle at full throughput.
REQ-022 A requester keeps req, cmd, addr and wdata stable until gnt; a requester that holds req after gnt issues a new request.
REQ-023 Each issued READ pushes an owner tag (A or B) into an RD_LAT-deep shift pipeline; WRITE and NONE push an empty tag.
REQ-024 When the tag exits the pipeline, x_rvalid=1 for one cycle for the owning port and x_rdata=mem_rdata; the other port's rvalid=0.
REQ-025 Read response is exactly 1+RD_LAT cycles after gnt.
REQ-026 WRITE produces no rvalid.
REQ-027 x_rdata is don't-care when x_rvalid=0, but is driven from mem_rdata without muxing logic beyond the tag.
REQ-028 Write followed by read to the same address on consecutive grants: ordering is preserved; the arbiter never reorders commands.

Reset
REQ-029 While reset=1: mem_cmd=NONE, mem_addr=0, mem_wdata=0, a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, pointer=PRI_A, tag pipeline empty.
REQ-030 Reset asserted mid-transaction discards all in-flight reads; no rvalid appears after reset is released for commands issued before reset.
REQ-031 The first cycle after reset release may grant.

Structure
REQ-032 The command encodings (NONE, READ, WRITE) and the owner-tag encoding (NONE, A, B) live in a shared package that cpu and memory also use.
REQ-033 The tag pipeline is a sub-module, rd_tag_pipe, parameterised by RD_LAT.
REQ-034 The pointer, the issue register and the grant logic stay in mem_arbiter.

Verification
REQ-035 Reset, then A only issues READ 0x005 with RD_LAT=1 -> a_gnt in cycle 0, mem_cmd=READ and mem_addr=0x005 in cycle 1, a_rvalid with mem_rdata in cycle 2, b_rvalid=0 throughout.
REQ-036 A and B request continuously for 6 cycles -> grants alternate A,B,A,B,A,B, and mem_cmd issues every cycle.
REQ-037 B WRITE 0x010 = 0xBEEF, then A READ 0x010 -> mem sees WRITE then READ in order, and a_rdata=0xBEEF.
REQ-038 With RD_LAT=3, A READ, B READ and A WRITE in consecutive cycles -> a_rvalid at cycle 4, b_rvalid at cycle 5, and no third rvalid.
REQ-039 A READ granted, then reset pulsed 1 cycle later -> no a_rvalid after reset, mem_cmd=NONE, and pointer=PRI_A.
REQ-040 a_req=1 with a_cmd=NONE and B idle -> no a_gnt and mem_cmd stays NONE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter, its requesters and the RAM model.
// Command and owner-tag values are fixed so cpu, loader and memory agree on them.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } cmd_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_A    = 2'b01,
    TAG_B    = 2'b10
  } tag_e;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  // 2'b11 is deliberately not an access: it behaves exactly like NONE.
  function automatic logic is_access(input logic [1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-owner tag delay line: a tag pushed with each issued command pops out
// RD_LAT cycles later, lined up with the RAM read data.
module rd_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  tag_e i_tag,
  output tag_e o_tag
);

  tag_e r_stage [RD_LAT];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LAT; i++) r_stage[i] <= TAG_NONE;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with fixed read latency.
// Priority pointer states:  PRI_A | A wins a conflict  ;  PRI_B | B wins a conflict
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW     = 9,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic [1:0]    a_cmd,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic [1:0]    b_cmd,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  pri_e          r_pri;
  logic [1:0]    r_cmd;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  tag_e          r_owner;

  logic w_a_elig;
  logic w_b_elig;
  logic w_a_win;
  logic w_b_win;
  tag_e w_push_tag;
  tag_e w_pop_tag;

  // Gating with reset keeps both grants low for the whole reset window.
  always_comb begin
    w_a_elig = a_req && is_access(a_cmd) && !reset;
    w_b_elig = b_req && is_access(b_cmd) && !reset;
    w_a_win  = w_a_elig && (!w_b_elig || (r_pri == PRI_A));
    w_b_win  = w_b_elig && !w_a_win;
  end

  assign a_gnt = w_a_win;
  assign b_gnt = w_b_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pri   <= PRI_A;
      r_cmd   <= CMD_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_owner <= TAG_NONE;
    end else if (w_a_win) begin
      r_pri   <= PRI_B;
      r_cmd   <= a_cmd;
      r_addr  <= a_addr;
      r_wdata <= a_wdata;
      r_owner <= TAG_A;
    end else if (w_b_win) begin
      r_pri   <= PRI_A;
      r_cmd   <= b_cmd;
      r_addr  <= b_addr;
      r_wdata <= b_wdata;
      r_owner <= TAG_B;
    end else begin
      r_cmd   <= CMD_NONE;
      r_owner <= TAG_NONE;
    end
  end

  assign mem_cmd   = r_cmd;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // Tag enters on the cycle the command is on the RAM bus, so it exits with mem_rdata.
  assign w_push_tag = (r_cmd == CMD_READ) ? r_owner : TAG_NONE;

  rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .i_clk(clk),
    .i_rst(reset),
    .i_tag(w_push_tag),
    .o_tag(w_pop_tag)
  );

  assign a_rvalid = (w_pop_tag == TAG_A);
  assign b_rvalid = (w_pop_tag == TAG_B);
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT 1 and 3) share the same requesters; a
// round-robin reference with a shadow memory predicts grants, RAM commands and read data.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_req, b_req;
  logic [1:0] a_cmd, b_cmd;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic a_gnt1, b_gnt1, a_rv1, b_rv1, a_gnt3, b_gnt3, a_rv3, b_rv3;
  logic [DW-1:0] a_rd1, b_rd1, a_rd3, b_rd3;
  logic [1:0] m_cmd1, m_cmd3;
  logic [AW-1:0] m_addr1, m_addr3;
  logic [DW-1:0] m_wdata1, m_wdata3, m_rdata1, m_rdata3;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_cmd(a_cmd), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rv1), .a_rdata(a_rd1),
    .b_req(b_req), .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rv1), .b_rdata(b_rd1),
    .mem_cmd(m_cmd1), .mem_addr(m_addr1), .mem_wdata(m_wdata1), .mem_rdata(m_rdata1)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_cmd(a_cmd), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt3), .a_rvalid(a_rv3), .a_rdata(a_rd3),
    .b_req(b_req), .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt3), .b_rvalid(b_rv3), .b_rdata(b_rd3),
    .mem_cmd(m_cmd3), .mem_addr(m_addr3), .mem_wdata(m_wdata3), .mem_rdata(m_rdata3)
  );

  // RAM models, one per latency
  logic [DW-1:0] mem1 [0:511];
  logic [DW-1:0] mem3 [0:511];
  logic [DW-1:0] shadow [0:511];
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd3 [0:2];

  always @(posedge clk) begin
    if (m_cmd1 == CMD_WRITE) mem1[m_addr1] <= m_wdata1;
    rd1 <= (m_cmd1 == CMD_READ) ? mem1[m_addr1] : DW'($urandom);
  end
  assign m_rdata1 = rd1;

  always @(posedge clk) begin
    if (m_cmd3 == CMD_WRITE) mem3[m_addr3] <= m_wdata3;
    rd3[0] <= (m_cmd3 == CMD_READ) ? mem3[m_addr3] : DW'($urandom);
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign m_rdata3 = rd3[2];

  typedef struct {int cyc; bit ga; bit gb;} gexp_t;
  typedef struct {int cyc; logic [1:0] cmd; logic [AW-1:0] addr; logic [DW-1:0] wdata;} mexp_t;
  typedef struct {int cyc; bit port_b; logic [DW-1:0] data;} rexp_t;

  gexp_t gq[$];
  mexp_t mq[$];
  rexp_t r1q[$];
  rexp_t r3q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Requester state and reference model state
  bit pa, pb;
  logic [1:0] ca, cb;
  logic [AW-1:0] aa, ab;
  logic [DW-1:0] da, db;
  bit ptr_b;

  task automatic issue(input bit port_b, input logic [1:0] c, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd);
    mexp_t m;
    rexp_t r;
    m.cyc = cyc + 1; m.cmd = c; m.addr = ad; m.wdata = wd;
    mq.push_back(m);
    if (c == CMD_READ) begin
      r.port_b = port_b;
      r.data   = shadow[ad];
      r.cyc    = cyc + 2;
      r1q.push_back(r);
      r.cyc    = cyc + 4;
      r3q.push_back(r);
    end else begin
      shadow[ad] = wd;
    end
  endtask

  task automatic drive_cycle(input bit rst_v);
    bit ea, eb, ga, gb;
    gexp_t g;
    @(posedge clk);
    #1;
    reset = rst_v;
    a_req = pa; a_cmd = ca; a_addr = aa; a_wdata = da;
    b_req = pb; b_cmd = cb; b_addr = ab; b_wdata = db;
    ga = 1'b0;
    gb = 1'b0;
    if (rst_v) begin
      mq.delete();
      r1q.delete();
      r3q.delete();
      ptr_b = 1'b0;
    end else begin
      ea = pa && (ca == CMD_READ || ca == CMD_WRITE);
      eb = pb && (cb == CMD_READ || cb == CMD_WRITE);
      if (ea && (!eb || !ptr_b)) ga = 1'b1;
      else if (eb) gb = 1'b1;
      if (ga) begin issue(1'b0, ca, aa, da); ptr_b = 1'b1; pa = 1'b0; end
      if (gb) begin issue(1'b1, cb, ab, db); ptr_b = 1'b0; pb = 1'b0; end
      if (pa && !ea) pa = 1'b0;
      if (pb && !eb) pb = 1'b0;
    end
    g.cyc = cyc; g.ga = ga; g.gb = gb;
    gq.push_back(g);
  endtask

  function automatic logic [1:0] rand_cmd();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return CMD_READ;
    if (r < 9) return CMD_WRITE;
    return 2'($urandom_range(0, 1) * 3);
  endfunction

  task automatic rand_reqs();
    if (!pa && $urandom_range(0, 3) != 0) begin
      pa = 1'b1; ca = rand_cmd(); aa = AW'($urandom_range(0, 15)); da = DW'($urandom);
    end
    if (!pb && $urandom_range(0, 3) != 0) begin
      pb = 1'b1; cb = rand_cmd(); ab = AW'($urandom_range(0, 15)); db = DW'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0);
  endtask

  gexp_t mon_g;
  mexp_t mon_m;
  rexp_t mon_r;

  always @(negedge clk) begin
    if (gq.size() != 0 && gq[0].cyc == cyc) begin
      mon_g = gq.pop_front();
      chk("a_gnt L1", 64'(a_gnt1), 64'(mon_g.ga));
      chk("b_gnt L1", 64'(b_gnt1), 64'(mon_g.gb));
      chk("a_gnt L3", 64'(a_gnt3), 64'(mon_g.ga));
      chk("b_gnt L3", 64'(b_gnt3), 64'(mon_g.gb));
    end
    if (mq.size() != 0 && mq[0].cyc == cyc) begin
      mon_m = mq.pop_front();
      chk("mem_cmd L1", 64'({m_cmd1, m_addr1, m_wdata1}), 64'({mon_m.cmd, mon_m.addr, mon_m.wdata}));
      chk("mem_cmd L3", 64'({m_cmd3, m_addr3, m_wdata3}), 64'({mon_m.cmd, mon_m.addr, mon_m.wdata}));
    end else if (m_cmd1 != CMD_NONE || m_cmd3 != CMD_NONE) begin
      chk("mem_cmd idle", 64'({m_cmd3, m_cmd1}), 64'(0));
    end
    if (r1q.size() != 0 && r1q[0].cyc == cyc) begin
      mon_r = r1q.pop_front();
      chk("rvalid L1", 64'({a_rv1, b_rv1}), 64'(mon_r.port_b ? 2'b01 : 2'b10));
      chk("rdata L1", 64'(mon_r.port_b ? b_rd1 : a_rd1), 64'(mon_r.data));
    end else if (a_rv1 || b_rv1) begin
      chk("rvalid idle L1", 64'({a_rv1, b_rv1}), 64'(0));
    end
    if (r3q.size() != 0 && r3q[0].cyc == cyc) begin
      mon_r = r3q.pop_front();
      chk("rvalid L3", 64'({a_rv3, b_rv3}), 64'(mon_r.port_b ? 2'b01 : 2'b10));
      chk("rdata L3", 64'(mon_r.port_b ? b_rd3 : a_rd3), 64'(mon_r.data));
    end else if (a_rv3 || b_rv3) begin
      chk("rvalid idle L3", 64'({a_rv3, b_rv3}), 64'(0));
    end
    if (reset) begin
      chk("reset mem bus L1", 64'({m_cmd1, m_addr1, m_wdata1}), 64'(0));
      chk("reset mem bus L3", 64'({m_cmd3, m_addr3, m_wdata3}), 64'(0));
      chk("reset rvalid", 64'({a_rv1, b_rv1, a_rv3, b_rv3}), 64'(0));
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem1[i]   = DW'(i * 37) ^ 16'h5a5a;
      mem3[i]   = DW'(i * 37) ^ 16'h5a5a;
      shadow[i] = DW'(i * 37) ^ 16'h5a5a;
    end
    pa = 1'b0; pb = 1'b0; ptr_b = 1'b0;
    ca = CMD_NONE; cb = CMD_NONE; aa = '0; ab = '0; da = '0; db = '0;
    a_req = 1'b0; b_req = 1'b0; a_cmd = CMD_NONE; b_cmd = CMD_NONE;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;

    // A READ 0x005 held through reset: no grant while reset, granted right after release
    pa = 1'b1; ca = CMD_READ; aa = 9'h005; da = 16'h1234;
    repeat (3) drive_cycle(1'b1);
    idle(6);

    // Both ports request continuously: alternating grants, one command per cycle
    drive_cycle(1'b1);
    for (int i = 0; i < 6; i++) begin
      if (!pa) begin pa = 1'b1; ca = CMD_READ;  aa = AW'(i);       da = DW'(i); end
      if (!pb) begin pb = 1'b1; cb = CMD_WRITE; ab = AW'(i + 32);  db = DW'(16'h100 + i); end
      drive_cycle(1'b0);
    end
    pa = 1'b0; pb = 1'b0;
    idle(5);

    // B WRITE 0x010 = 0xBEEF, then A READ 0x010
    pb = 1'b1; cb = CMD_WRITE; ab = 9'h010; db = 16'hBEEF;
    drive_cycle(1'b0);
    pa = 1'b1; ca = CMD_READ; aa = 9'h010; da = 16'h0;
    drive_cycle(1'b0);
    idle(5);

    // A READ, B READ, A WRITE on consecutive cycles
    pa = 1'b1; ca = CMD_READ;  aa = 9'h020; drive_cycle(1'b0);
    pb = 1'b1; cb = CMD_READ;  ab = 9'h021; drive_cycle(1'b0);
    pa = 1'b1; ca = CMD_WRITE; aa = 9'h022; da = 16'h7777; drive_cycle(1'b0);
    idle(6);

    // A READ then a one-cycle reset: in-flight read discarded, pointer back to A
    pa = 1'b1; ca = CMD_READ; aa = 9'h030; drive_cycle(1'b0);
    drive_cycle(1'b1);
    idle(5);
    pa = 1'b1; ca = CMD_READ; aa = 9'h031;
    pb = 1'b1; cb = CMD_READ; ab = 9'h032;
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    idle(5);

    // Requests carrying NONE or 2'b11 are ignored
    for (int i = 0; i < 3; i++) begin
      pa = 1'b1; ca = CMD_NONE; aa = 9'h040;
      drive_cycle(1'b0);
    end
    pa = 1'b1; ca = 2'b11; drive_cycle(1'b0);
    pb = 1'b1; cb = 2'b11; drive_cycle(1'b0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      rand_reqs();
      drive_cycle(1'b0);
    end
    pa = 1'b0; pb = 1'b0;
    idle(8);

    chk("scoreboard drained", 64'(mq.size() + r1q.size() + r3q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
